rename_map_unit: RTL and testbench

RENAME_MAP_UNIT -- requirements
Module: rename_map_unit

---
 rtl/mips_core_pkg.sv | 34 +++
 rtl/rename_free_list.sv | 61 ++++++
 rtl/rename_map_unit.sv | 212 +++++++++++++++++++++
 tb/tb_rename_map_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared types and default sizes for the register rename unit.
// The checkpoint struct pairs a full RMT snapshot with the free-list head pointer.
package mips_core_pkg;

    localparam int NUM_ARCH_REGS_DEFAULT = 32;
    localparam int NUM_PHYS_REGS_DEFAULT = 64;
    localparam int NUM_CKPTS_DEFAULT     = 4;

    localparam int ARCH_W   = $clog2(NUM_ARCH_REGS_DEFAULT);
    localparam int PHYS_W   = $clog2(NUM_PHYS_REGS_DEFAULT);
    localparam int CKPT_W   = $clog2(NUM_CKPTS_DEFAULT);
    localparam int FL_DEPTH = NUM_PHYS_REGS_DEFAULT - NUM_ARCH_REGS_DEFAULT;
    localparam int FL_PTR_W = $clog2(FL_DEPTH);

    typedef logic [PHYS_W-1:0] phys_reg_t;
    typedef logic [CKPT_W-1:0] ckpt_id_t;
    typedef logic [FL_PTR_W:0] fl_ptr_t;
    typedef logic [CKPT_W:0]   ckpt_ptr_t;
    typedef phys_reg_t [NUM_ARCH_REGS_DEFAULT-1:0] rmt_t;

    typedef struct packed {
        rmt_t    rmt;
        fl_ptr_t fl_head;
    } ckpt_t;

    // A writeback landing in the same cycle as the read wins over the stored busy bit.
    function automatic logic src_busy(input logic [NUM_PHYS_REGS_DEFAULT-1:0] busy,
                                      input phys_reg_t phys,
                                      input logic      wb_valid,
                                      input phys_reg_t wb_phys);
        return busy[phys] && !(wb_valid && (wb_phys == phys));
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical registers; head may be rewound on recovery.
// Pointers carry a wrap bit so full and empty are distinguishable from head/tail alone.
module rename_free_list
    import mips_core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [PHYS_W-1:0]   push_data,
    input  logic                pop,
    input  logic                restore,
    input  logic [FL_PTR_W:0]   restore_head,
    output logic [PHYS_W-1:0]   head_data,
    output logic [FL_PTR_W:0]   head_ptr,
    output logic [FL_PTR_W:0]   count
);

    phys_reg_t mem_q [FL_DEPTH];
    phys_reg_t mem_d [FL_DEPTH];
    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;

    // Push at the tail is independent of head movement, so commits survive a restore.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            mem_d[tail_q[FL_PTR_W-1:0]] = push_data;
            tail_d                      = tail_q + fl_ptr_t'(1);
        end else begin
            tail_d = tail_q;
        end
        if (restore) begin
            head_d = restore_head;
        end else if (pop) begin
            head_d = head_q + fl_ptr_t'(1);
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= phys_reg_t'(NUM_ARCH_REGS_DEFAULT + i);
            end
            head_q <= fl_ptr_t'(0);
            tail_q <= fl_ptr_t'(FL_DEPTH);
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data = mem_q[head_q[FL_PTR_W-1:0]];
    assign head_ptr  = head_q;
    assign count     = tail_q - head_q;

endmodule

// File: rtl/rename_map_unit.sv
// Register rename stage: RMT lookup/update, busy table, free list and branch checkpoints,
// with a single registered output slot toward issue.
module rename_map_unit
    import mips_core_pkg::*;
#(
    parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEFAULT,
    parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEFAULT,
    parameter int NUM_CKPTS     = NUM_CKPTS_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_uses_rw,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0] in_rw_addr,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0] in_rs_addr,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0] in_rt_addr,
    input  logic                             in_is_branch,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] out_rs_phys,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] out_rt_phys,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] out_rw_phys,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] out_old_rw_phys,
    output logic                             out_rs_busy,
    output logic                             out_rt_busy,
    output logic [$clog2(NUM_CKPTS)-1:0]     out_ckpt_id,
    input  logic                             wb_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0] wb_phys,
    input  logic                             commit_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0] commit_free_phys,
    input  logic                             recover_valid,
    input  logic [$clog2(NUM_CKPTS)-1:0]     recover_ckpt_id,
    input  logic                             release_valid
);

    localparam ckpt_ptr_t CKPT_FULL = ckpt_ptr_t'(NUM_CKPTS);

    rmt_t                             rmt_q, rmt_d;
    logic [NUM_PHYS_REGS_DEFAULT-1:0] busy_q, busy_d;
    ckpt_t                            ckpt_q [NUM_CKPTS];
    ckpt_t                            ckpt_d [NUM_CKPTS];
    ckpt_ptr_t                        ckpt_head_q, ckpt_head_d, ckpt_tail_q, ckpt_tail_d;
    ckpt_ptr_t                        ckpt_cnt_s;
    ckpt_id_t                         rec_off_s;
    ckpt_t                            snap_s;
    logic do_alloc_s, ckpt_full_s, fl_empty_s, in_ready_s, fire_s, alloc_fire_s, ckpt_take_s;
    phys_reg_t fl_head_data_s;
    fl_ptr_t   fl_head_ptr_s, fl_count_s;

    logic      out_valid_q, out_valid_d, out_rs_busy_q, out_rs_busy_d, out_rt_busy_q, out_rt_busy_d;
    phys_reg_t out_rs_phys_q, out_rs_phys_d, out_rt_phys_q, out_rt_phys_d;
    phys_reg_t out_rw_phys_q, out_rw_phys_d, out_old_rw_phys_q, out_old_rw_phys_d;
    ckpt_id_t  out_ckpt_id_q, out_ckpt_id_d;

    rename_free_list u_free_list (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (commit_valid),
        .push_data    (commit_free_phys),
        .pop          (alloc_fire_s),
        .restore      (recover_valid),
        .restore_head (ckpt_q[recover_ckpt_id].fl_head),
        .head_data    (fl_head_data_s),
        .head_ptr     (fl_head_ptr_s),
        .count        (fl_count_s)
    );

    // Accept only when every resource the instruction needs is already available this cycle.
    always_comb begin
        do_alloc_s   = in_uses_rw && (in_rw_addr != {ARCH_W{1'b0}});
        ckpt_cnt_s   = ckpt_tail_q - ckpt_head_q;
        ckpt_full_s  = (ckpt_cnt_s == CKPT_FULL);
        fl_empty_s   = (fl_count_s == {(FL_PTR_W+1){1'b0}});
        in_ready_s   = (!out_valid_q || out_ready) && !recover_valid
                       && (!do_alloc_s || !fl_empty_s) && (!in_is_branch || !ckpt_full_s);
        fire_s       = in_valid && in_ready_s;
        alloc_fire_s = fire_s && do_alloc_s;
        ckpt_take_s  = fire_s && in_is_branch;
    end

    // Snapshot reflects the branch's own destination update and its own pop.
    always_comb begin
        rmt_d  = rmt_q;
        busy_d = busy_q;
        if (recover_valid) begin
            rmt_d = ckpt_q[recover_ckpt_id].rmt;
        end else if (alloc_fire_s) begin
            rmt_d[in_rw_addr] = fl_head_data_s;
        end else begin
            rmt_d = rmt_q;
        end
        if (wb_valid) begin
            busy_d[wb_phys] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (alloc_fire_s) begin
            busy_d[fl_head_data_s] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        snap_s.rmt     = rmt_d;
        snap_s.fl_head = fl_head_ptr_s + (alloc_fire_s ? fl_ptr_t'(1) : fl_ptr_t'(0));
    end

    // Recovery truncates the queue at the recovered entry; release of that same entry is moot.
    always_comb begin
        ckpt_d      = ckpt_q;
        ckpt_head_d = ckpt_head_q;
        ckpt_tail_d = ckpt_tail_q;
        rec_off_s   = recover_ckpt_id - ckpt_head_q[CKPT_W-1:0];
        if (recover_valid) begin
            ckpt_tail_d = ckpt_head_q + {1'b0, rec_off_s};
            if (release_valid && (rec_off_s != {CKPT_W{1'b0}})) begin
                ckpt_head_d = ckpt_head_q + ckpt_ptr_t'(1);
            end else begin
                ckpt_head_d = ckpt_head_q;
            end
        end else begin
            if (ckpt_take_s) begin
                ckpt_d[ckpt_tail_q[CKPT_W-1:0]] = snap_s;
                ckpt_tail_d                     = ckpt_tail_q + ckpt_ptr_t'(1);
            end else begin
                ckpt_tail_d = ckpt_tail_q;
            end
            if (release_valid && (ckpt_cnt_s != ckpt_ptr_t'(0))) begin
                ckpt_head_d = ckpt_head_q + ckpt_ptr_t'(1);
            end else begin
                ckpt_head_d = ckpt_head_q;
            end
        end
    end

    // Sources read the pre-update RMT so rs == rw returns the previous mapping.
    always_comb begin
        out_rs_phys_d     = out_rs_phys_q;
        out_rt_phys_d     = out_rt_phys_q;
        out_rw_phys_d     = out_rw_phys_q;
        out_old_rw_phys_d = out_old_rw_phys_q;
        out_rs_busy_d     = out_rs_busy_q;
        out_rt_busy_d     = out_rt_busy_q;
        out_ckpt_id_d     = out_ckpt_id_q;
        if (recover_valid) begin
            out_valid_d = 1'b0;
        end else if (fire_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (fire_s) begin
            out_rs_phys_d     = rmt_q[in_rs_addr];
            out_rt_phys_d     = rmt_q[in_rt_addr];
            out_rw_phys_d     = do_alloc_s ? fl_head_data_s : phys_reg_t'(0);
            out_old_rw_phys_d = do_alloc_s ? rmt_q[in_rw_addr] : phys_reg_t'(0);
            out_rs_busy_d     = src_busy(busy_q, rmt_q[in_rs_addr], wb_valid, wb_phys);
            out_rt_busy_d     = src_busy(busy_q, rmt_q[in_rt_addr], wb_valid, wb_phys);
            out_ckpt_id_d     = in_is_branch ? ckpt_tail_q[CKPT_W-1:0] : ckpt_id_t'(0);
        end else begin
            out_rs_phys_d = out_rs_phys_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS_DEFAULT; i++) begin
                rmt_q[i] <= phys_reg_t'(i);
            end
            for (int i = 0; i < NUM_CKPTS; i++) begin
                ckpt_q[i] <= ckpt_t'(0);
            end
            busy_q            <= {NUM_PHYS_REGS_DEFAULT{1'b0}};
            ckpt_head_q       <= ckpt_ptr_t'(0);
            ckpt_tail_q       <= ckpt_ptr_t'(0);
            out_valid_q       <= 1'b0;
            out_rs_phys_q     <= phys_reg_t'(0);
            out_rt_phys_q     <= phys_reg_t'(0);
            out_rw_phys_q     <= phys_reg_t'(0);
            out_old_rw_phys_q <= phys_reg_t'(0);
            out_rs_busy_q     <= 1'b0;
            out_rt_busy_q     <= 1'b0;
            out_ckpt_id_q     <= ckpt_id_t'(0);
        end else begin
            rmt_q             <= rmt_d;
            ckpt_q            <= ckpt_d;
            busy_q            <= busy_d;
            ckpt_head_q       <= ckpt_head_d;
            ckpt_tail_q       <= ckpt_tail_d;
            out_valid_q       <= out_valid_d;
            out_rs_phys_q     <= out_rs_phys_d;
            out_rt_phys_q     <= out_rt_phys_d;
            out_rw_phys_q     <= out_rw_phys_d;
            out_old_rw_phys_q <= out_old_rw_phys_d;
            out_rs_busy_q     <= out_rs_busy_d;
            out_rt_busy_q     <= out_rt_busy_d;
            out_ckpt_id_q     <= out_ckpt_id_d;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_q;
    assign out_rs_phys     = out_rs_phys_q;
    assign out_rt_phys     = out_rt_phys_q;
    assign out_rw_phys     = out_rw_phys_q;
    assign out_old_rw_phys = out_old_rw_phys_q;
    assign out_rs_busy     = out_rs_busy_q;
    assign out_rt_busy     = out_rt_busy_q;
    assign out_ckpt_id     = out_ckpt_id_q;

endmodule

// File: tb/tb_rename_map_unit.sv
// Directed bench for rename_map_unit: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_rename_map_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_uses_rw, in_is_branch;
    logic [4:0] in_rw_addr, in_rs_addr, in_rt_addr;
    logic       out_valid, out_ready, out_rs_busy, out_rt_busy;
    logic [5:0] out_rs_phys, out_rt_phys, out_rw_phys, out_old_rw_phys;
    logic [1:0] out_ckpt_id, recover_ckpt_id;
    logic       wb_valid, commit_valid, recover_valid, release_valid;
    logic [5:0] wb_phys, commit_free_phys;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rename_map_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_uses_rw(in_uses_rw),
        .in_rw_addr(in_rw_addr), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_is_branch(in_is_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_phys(out_rs_phys), .out_rt_phys(out_rt_phys),
        .out_rw_phys(out_rw_phys), .out_old_rw_phys(out_old_rw_phys),
        .out_rs_busy(out_rs_busy), .out_rt_busy(out_rt_busy), .out_ckpt_id(out_ckpt_id),
        .wb_valid(wb_valid), .wb_phys(wb_phys),
        .commit_valid(commit_valid), .commit_free_phys(commit_free_phys),
        .recover_valid(recover_valid), .recover_ckpt_id(recover_ckpt_id),
        .release_valid(release_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_uses_rw = 1'b0; in_is_branch = 1'b0;
        in_rw_addr = 5'd0; in_rs_addr = 5'd0; in_rt_addr = 5'd0;
        wb_valid = 1'b0; wb_phys = 6'd0; commit_valid = 1'b0; commit_free_phys = 6'd0;
        recover_valid = 1'b0; recover_ckpt_id = 2'd0; release_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic ren(input logic uses, input logic [4:0] rw, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br);
        in_valid = 1'b1; in_uses_rw = uses; in_rw_addr = rw;
        in_rs_addr = rs; in_rt_addr = rt; in_is_branch = br;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++; if (out_rs_phys !== 6'd0 || out_rw_phys !== 6'd0 || out_old_rw_phys !== 6'd0) begin n_fail++; $display("FAIL reset_out_fields: got rs=%0d rw=%0d old=%0d expected 0", out_rs_phys, out_rw_phys, out_old_rw_phys); end
        n_checks++; if (out_ckpt_id !== 2'd0 || out_rs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_ckpt_busy: got ckpt=%0d busy=%0b expected 0/0", out_ckpt_id, out_rs_busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        ren(1'b1, 5'd3, 5'd1, 5'd2, 1'b0);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rs_phys !== 6'd1 || out_rt_phys !== 6'd2) begin n_fail++; $display("FAIL basic_src: got v=%0b rs=%0d rt=%0d expected 1/1/2", out_valid, out_rs_phys, out_rt_phys); end
        n_checks++; if (out_rw_phys !== 6'd32 || out_old_rw_phys !== 6'd3) begin n_fail++; $display("FAIL basic_dst: got rw=%0d old=%0d expected 32/3", out_rw_phys, out_old_rw_phys); end
        n_checks++; if (out_rs_busy !== 1'b0 || out_rt_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy0: got %0b/%0b expected 0/0", out_rs_busy, out_rt_busy); end
        ren(1'b1, 5'd4, 5'd3, 5'd3, 1'b0);
        tick();
        n_checks++; if (out_rs_phys !== 6'd32 || out_rt_phys !== 6'd32) begin n_fail++; $display("FAIL dep_src: got rs=%0d rt=%0d expected 32/32", out_rs_phys, out_rt_phys); end
        n_checks++; if (out_rs_busy !== 1'b1 || out_rt_busy !== 1'b1) begin n_fail++; $display("FAIL dep_busy: got %0b/%0b expected 1/1", out_rs_busy, out_rt_busy); end
        n_checks++; if (out_rw_phys !== 6'd33 || out_old_rw_phys !== 6'd4) begin n_fail++; $display("FAIL dep_dst: got rw=%0d old=%0d expected 33/4", out_rw_phys, out_old_rw_phys); end
        ren(1'b1, 5'd0, 5'd5, 5'd4, 1'b0);
        tick();
        n_checks++; if (out_rw_phys !== 6'd0 || out_old_rw_phys !== 6'd0 || out_rs_phys !== 6'd5 || out_rt_phys !== 6'd33) begin n_fail++; $display("FAIL r0_dst: got rw=%0d old=%0d rs=%0d rt=%0d expected 0/0/5/33", out_rw_phys, out_old_rw_phys, out_rs_phys, out_rt_phys); end
        ren(1'b1, 5'd6, 5'd6, 5'd0, 1'b0);
        tick();
        n_checks++; if (out_rw_phys !== 6'd34 || out_rs_phys !== 6'd6) begin n_fail++; $display("FAIL r0_no_pop: got rw=%0d rs=%0d expected 34/6", out_rw_phys, out_rs_phys); end
        idle();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_free_list_full();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            ren(1'b1, 5'(i % 31 + 1), 5'd0, 5'd0, 1'b0);
            tick();
        end
        n_checks++; if (out_rw_phys !== 6'd63) begin n_fail++; $display("FAIL fl_last: got %0d expected 63", out_rw_phys); end
        ren(1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_empty_stall: got %0b expected 0", in_ready); end
        ren(1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_empty_noalloc: got %0b expected 1", in_ready); end
        ren(1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
        commit_valid = 1'b1; commit_free_phys = 6'd5;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_no_bypass: got %0b expected 0", in_ready); end
        tick();
        commit_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_after_commit: got %0b expected 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rw_phys !== 6'd5) begin n_fail++; $display("FAIL fl_reuse: got v=%0b rw=%0d expected 1/5", out_valid, out_rw_phys); end
        idle();
    endtask

    task automatic test_recover();
        do_reset();
        ren(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        n_checks++; if (out_ckpt_id !== 2'd0 || out_rw_phys !== 6'd0) begin n_fail++; $display("FAIL br_ckpt: got ckpt=%0d rw=%0d expected 0/0", out_ckpt_id, out_rw_phys); end
        for (int i = 0; i < 3; i++) begin
            ren(1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
            tick();
        end
        n_checks++; if (out_rw_phys !== 6'd34 || out_old_rw_phys !== 6'd33 || out_rs_phys !== 6'd33) begin n_fail++; $display("FAIL r7_chain: got rw=%0d old=%0d rs=%0d expected 34/33/33", out_rw_phys, out_old_rw_phys, out_rs_phys); end
        ren(1'b1, 5'd8, 5'd7, 5'd0, 1'b0);
        recover_valid = 1'b1; recover_ckpt_id = 2'd0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rec_priority: got %0b expected 0", in_ready); end
        tick();
        recover_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rec_kill: got %0b expected 0", out_valid); end
        tick();
        n_checks++; if (out_rs_phys !== 6'd7 || out_rw_phys !== 6'd32 || out_old_rw_phys !== 6'd8) begin n_fail++; $display("FAIL rec_restore: got rs=%0d rw=%0d old=%0d expected 7/32/8", out_rs_phys, out_rw_phys, out_old_rw_phys); end
        idle();
    endtask

    task automatic test_wb_bypass();
        do_reset();
        ren(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        tick();
        ren(1'b0, 5'd0, 5'd3, 5'd3, 1'b0);
        wb_valid = 1'b1; wb_phys = 6'd32;
        tick();
        wb_valid = 1'b0;
        n_checks++; if (out_rs_phys !== 6'd32 || out_rs_busy !== 1'b0 || out_rt_busy !== 1'b0) begin n_fail++; $display("FAIL wb_bypass: got rs=%0d busy=%0b/%0b expected 32/0/0", out_rs_phys, out_rs_busy, out_rt_busy); end
        ren(1'b0, 5'd0, 5'd3, 5'd0, 1'b0);
        tick();
        n_checks++; if (out_rs_busy !== 1'b0) begin n_fail++; $display("FAIL wb_cleared: got %0b expected 0", out_rs_busy); end
        idle();
    endtask

    task automatic test_ckpt_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ren(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
            tick();
            n_checks++; if (out_ckpt_id !== 2'(i)) begin n_fail++; $display("FAIL ckpt_alloc%0d: got %0d expected %0d", i, out_ckpt_id, i); end
        end
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ckpt_full_stall: got %0b expected 0", in_ready); end
        release_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ckpt_rel_same_cycle: got %0b expected 0", in_ready); end
        tick();
        release_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ckpt_after_rel: got %0b expected 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_ckpt_id !== 2'd0) begin n_fail++; $display("FAIL ckpt_wrap: got v=%0b id=%0d expected 1/0", out_valid, out_ckpt_id); end
        idle();
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        out_ready = 1'b0;
        ren(1'b1, 5'd9, 5'd1, 5'd2, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rw_phys !== 6'd32 || out_ckpt_id !== 2'd0) begin n_fail++; $display("FAIL stall_first: got v=%0b rw=%0d id=%0d expected 1/32/0", out_valid, out_rw_phys, out_ckpt_id); end
        ren(1'b1, 5'd10, 5'd9, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got %0b expected 0", i, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_rw_phys !== 6'd32 || out_rs_phys !== 6'd1) begin n_fail++; $display("FAIL stall_hold%0d: got v=%0b rw=%0d rs=%0d expected 1/32/1", i, out_valid, out_rw_phys, out_rs_phys); end
        end
        recover_valid = 1'b1; recover_ckpt_id = 2'd0;
        tick();
        recover_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_recover: got %0b expected 0", out_valid); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_rs_phys !== 6'd32 || out_rw_phys !== 6'd33 || out_old_rw_phys !== 6'd10) begin n_fail++; $display("FAIL ckpt_post_update: got rs=%0d rw=%0d old=%0d expected 32/33/10", out_rs_phys, out_rw_phys, out_old_rw_phys); end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_rw_phys !== 6'd0) begin n_fail++; $display("FAIL midreset: got v=%0b rw=%0d expected 0/0", out_valid, out_rw_phys); end
        idle();
        #10;
        rst_n = 1'b1;
        tick();
        ren(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        tick();
        n_checks++; if (out_rs_phys !== 6'd9 || out_rw_phys !== 6'd32) begin n_fail++; $display("FAIL midreset_state: got rs=%0d rw=%0d expected 9/32", out_rs_phys, out_rw_phys); end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_free_list_full();
        test_recover();
        test_wb_bypass();
        test_ckpt_full();
        test_back_to_back_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
